// File: rtl/mantissa_sub_normalize.sv
// -----------------------------------------------------------------------------
// mantissa_sub_normalize
//   Sequential subtract-and-normalize unit for the FPU datapath. Accepts two
//   exponent-aligned mantissas, forms |A-B|, then left-normalizes the result one
//   bit per cycle, decrementing the exponent on each shift. The exponent never
//   goes below 1 through shifting; a result that cannot be normalized before
//   the exponent floor is flagged denorm.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake (accept only in IDLE)
//   mant_a, mant_b      aligned mantissas, sampled on the accept cycle only
//   exp_in              common (larger) biased exponent
//   out_valid/out_ready result handshake (result held while out_ready=0)
//   mant_out, exp_out   normalized magnitude and adjusted exponent
//   swap                A<B, caller must invert the result sign
//   zero                result is exactly zero (exp_out forced to 0)
//   denorm              normalization stopped at the exponent floor
//
// States
//   S_IDLE | waiting for operands, in_ready=1
//   S_NORM | shifting left one bit per cycle until normalized/zero/floor
//   S_DONE | result presented, out_valid=1
// -----------------------------------------------------------------------------
module mantissa_sub_normalize #(
    parameter int WIDTH = 27,
    parameter int EXPW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mant_a,
    input  logic [WIDTH-1:0] mant_b,
    input  logic [EXPW-1:0]  exp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mant_out,
    output logic [EXPW-1:0]  exp_out,
    output logic             swap,
    output logic             zero,
    output logic             denorm
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mant_q, mant_d;
    logic [EXPW-1:0]  exp_q, exp_d;
    logic             swap_q, swap_d;
    logic             zero_q, zero_d;
    logic             denorm_q, denorm_d;

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        swap_d   = swap_q;
        zero_d   = zero_q;
        denorm_d = denorm_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (mant_a >= mant_b) begin
                        mant_d = mant_a - mant_b;
                        swap_d = 1'b0;
                    end else begin
                        mant_d = mant_b - mant_a;
                        swap_d = 1'b1;
                    end
                    exp_d    = exp_in;
                    zero_d   = 1'b0;
                    denorm_d = 1'b0;
                    state_d  = S_NORM;
                end
            end
            S_NORM: begin
                if (mant_q == '0) begin
                    zero_d  = 1'b1;
                    exp_d   = '0;
                    state_d = S_DONE;
                end else if (mant_q[WIDTH-1]) begin
                    state_d = S_DONE;
                end else if (exp_q <= EXPW'(1)) begin
                    // Shifting further would take the exponent below 1.
                    denorm_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    mant_d = {mant_q[WIDTH-2:0], 1'b0};
                    exp_d  = exp_q - EXPW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            swap_q   <= 1'b0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            swap_q   <= swap_d;
            zero_q   <= zero_d;
            denorm_q <= denorm_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign mant_out  = mant_q;
    assign exp_out   = exp_q;
    assign swap      = swap_q;
    assign zero      = zero_q;
    assign denorm    = denorm_q;

endmodule

// File: tb/tb_mantissa_sub_normalize.sv
module tb_mantissa_sub_normalize;

    localparam int WIDTH = 27;
    localparam int EXPW  = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mant_a;
    logic [WIDTH-1:0] mant_b;
    logic [EXPW-1:0]  exp_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] mant_out;
    logic [EXPW-1:0]  exp_out;
    logic             swap;
    logic             zero;
    logic             denorm;

    int n_checks = 0;
    int n_fail   = 0;

    mantissa_sub_normalize #(.WIDTH(WIDTH), .EXPW(EXPW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mant_a   (mant_a),
        .mant_b   (mant_b),
        .exp_in   (exp_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mant_out (mant_out),
        .exp_out  (exp_out),
        .swap     (swap),
        .zero     (zero),
        .denorm   (denorm)
    );

    always #5 CLK = ~CLK;

    // Result vector: {mant, exp, swap, zero, denorm}
    typedef logic [WIDTH+EXPW+2:0] res_t;

    // Closed-form reference: shift count = min(leading zeros, exp-1), floor at exp 1.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [EXPW-1:0] e, output int k);
        int unsigned ua, ub, diff, lz, room, ex;
        logic sw, dn;
        ua = a; ub = b;
        sw = (ua < ub);
        diff = sw ? ub - ua : ua - ub;
        k = 0;
        if (diff == 0) return {WIDTH'(0), EXPW'(0), sw, 1'b1, 1'b0};
        lz = 0;
        while (diff < (1 << (WIDTH-1))) begin
            diff = diff * 2;
            lz++;
        end
        ex   = e;
        room = (ex > 1) ? ex - 1 : 0;
        k    = (lz < room) ? lz : room;
        dn   = (lz > k);
        diff = diff >> (lz - k);
        return {WIDTH'(diff), EXPW'(ex - k), sw, 1'b0, dn};
    endfunction

    // Called at a negedge with the unit in IDLE; returns at a negedge in IDLE.
    task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [EXPW-1:0] e, input int stall, input bit noisy);
        res_t exp_res, got, held;
        int   k, cyc;
        exp_res = model(a, b, e, k);
        mant_a = a; mant_b = b; exp_in = e; in_valid = 1'b1; out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready_before_accept got=%b exp=1", name, in_ready);
        end
        @(negedge CLK);
        in_valid = noisy;
        mant_a = WIDTH'($urandom); mant_b = WIDTH'($urandom); exp_in = EXPW'($urandom);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (noisy) begin
                mant_a = WIDTH'($urandom); mant_b = WIDTH'($urandom); exp_in = EXPW'($urandom);
            end
        end
        n_checks++;
        if (cyc != 2 + k) begin
            n_fail++;
            $display("FAIL %s latency got=%0d exp=%0d", name, cyc, 2 + k);
        end
        got = {mant_out, exp_out, swap, zero, denorm};
        n_checks++;
        if (got !== exp_res) begin
            n_fail++;
            $display("FAIL %s result got mant=%h exp=%0d sw=%b z=%b dn=%b want mant=%h exp=%0d sw=%b z=%b dn=%b",
                     name, mant_out, exp_out, swap, zero, denorm,
                     exp_res[WIDTH+EXPW+2:EXPW+3], exp_res[EXPW+2:3], exp_res[2], exp_res[1], exp_res[0]);
        end
        held = got;
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({mant_out, exp_out, swap, zero, denorm} !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall_hold cyc=%0d got=%h v=%b r=%b exp=%h v=1 r=0",
                         name, i, {mant_out, exp_out, swap, zero, denorm}, out_valid, in_ready, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_handshake out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mant_a = '0; mant_b = '0; exp_in = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({in_ready, out_valid, mant_out, exp_out, swap, zero, denorm} !== {1'b1, 1'b0, WIDTH'(0), EXPW'(0), 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state in_ready=%b out_valid=%b mant=%h exp=%0d sw=%b z=%b dn=%b want 1 0 0 0 0 0 0",
                     in_ready, out_valid, mant_out, exp_out, swap, zero, denorm);
        end
    endtask

    task automatic test_directed();
        do_op("t1_one_shift",  27'h4000000, 27'h2000000, 8'd100, 0, 1'b0);
        do_op("t2_swap",       27'h0000001, 27'h4000001, 8'd50,  0, 1'b0);
        do_op("t3_equal",      27'h5A5A5A5, 27'h5A5A5A5, 8'd77,  0, 1'b0);
        do_op("t4_denorm",     27'h0000010, 27'h0000000, 8'd3,   0, 1'b0);
        do_op("t5_26_shifts",  27'h0000001, 27'h0000000, 8'd200, 0, 1'b0);
        do_op("exp0_denorm",   27'h0000100, 27'h0000000, 8'd0,   0, 1'b0);
        do_op("exp1_denorm",   27'h0000003, 27'h0000001, 8'd1,   0, 1'b0);
        do_op("equal_zero_e0", 27'h7FFFFFF, 27'h7FFFFFF, 8'd0,   0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op("bp_stall5", 27'h0001234, 27'h0000234, 8'd120, 5, 1'b1);
    endtask

    task automatic test_reset_midflight();
        mant_a = 27'h0000001; mant_b = 27'h0; exp_in = 8'd200; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1; out_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, mant_out, exp_out, swap, zero, denorm} !== {1'b1, 1'b0, WIDTH'(0), EXPW'(0), 3'b000}) begin
            n_fail++;
            $display("FAIL reset_midflight in_ready=%b out_valid=%b mant=%h exp=%0d sw=%b z=%b dn=%b want 1 0 0 0 0 0 0",
                     in_ready, out_valid, mant_out, exp_out, swap, zero, denorm);
        end
        repeat (40) @(negedge CLK);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard out_valid=%b exp=0", out_valid);
        end
        do_op("after_reset", 27'h2000000, 27'h1000000, 8'd10, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b;
        logic [EXPW-1:0]  e;
        for (int i = 0; i < 60; i++) begin
            a = WIDTH'($urandom) >> $urandom_range(0, WIDTH-1);
            b = ($urandom_range(0, 7) == 0) ? a : (WIDTH'($urandom) >> $urandom_range(0, WIDTH-1));
            e = ($urandom_range(0, 2) == 0) ? EXPW'($urandom_range(0, 6)) : EXPW'($urandom);
            do_op($sformatf("rand%0d", i), a, b, e, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
